// File: rtl/ttl269_sequencer_pkg.sv
// ttl269_sequencer_pkg
//   Shared definitions for the MC74F269 interval sequencer:
//   controller state encoding and active-low control levels.
package ttl269_sequencer_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOAD = 2'd1,
    ST_RUN  = 2'd2,
    ST_DONE = 2'd3
  } state_t;

  // Levels for the counter's active-low PE_n / CEP_n / CET_n pins
  localparam logic ASSERT_N   = 1'b0;
  localparam logic DEASSERT_N = 1'b1;

endpackage

// File: rtl/ttl269_sequencer_if.sv
// ttl269_sequencer_if
//   Command channel into the sequencer (valid/ready handshake).
//   cmd_valid  : command offered (master -> slave)
//   cmd_ready  : sequencer can accept (slave -> master)
//   cmd_value  : value loaded into the counter
//   cmd_up     : 1 = count up, 0 = count down
//   cmd_reload : 1 = auto-reload, 0 = one-shot
interface ttl269_sequencer_if #(
  parameter int DATA_WIDTH = 8
);
  logic                  cmd_valid;
  logic                  cmd_ready;
  logic [DATA_WIDTH-1:0] cmd_value;
  logic                  cmd_up;
  logic                  cmd_reload;

  modport master (output cmd_valid, cmd_value, cmd_up, cmd_reload, input cmd_ready);
  modport slave  (input cmd_valid, cmd_value, cmd_up, cmd_reload, output cmd_ready);
endinterface

// File: rtl/ttl269_sequencer_sat_counter.sv
// ttl269_sequencer_sat_counter
//   CNT_W-bit counter with synchronous clear that sticks at all-ones.
//   i_clk  : clock
//   i_rst  : synchronous reset, active-high
//   i_clr  : synchronous clear
//   i_inc  : increment request
//   o_cnt  : current count
module ttl269_sequencer_sat_counter #(
  parameter int CNT_W = 16
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_clr,
  input  logic             i_inc,
  output logic [CNT_W-1:0] o_cnt
);
  logic [CNT_W-1:0] r_cnt;

  always_ff @(posedge i_clk) begin
    if (i_rst || i_clr)
      r_cnt <= '0;
    else if (i_inc && (r_cnt != {CNT_W{1'b1}}))
      r_cnt <= r_cnt + 1'b1;
  end

  assign o_cnt = r_cnt;
endmodule

// File: rtl/ttl269_sequencer.sv
// ttl269_sequencer
//   Command-driven controller for one external MC74F269-style 8-bit
//   up/down counter. Accepts a command, loads the counter, runs it to
//   terminal count, then stops (one-shot) or reloads (auto-reload).
//   i_clk, i_rst      : clock, synchronous active-high reset
//   i_cmd             : command channel (slave modport)
//   i_pause, i_abort  : hold counting / stop current operation
//   o_ctr_pe_n/u_d/cep_n/cet_n/p : drive the counter
//   i_ctr_tc          : counter terminal count (combinational in the part)
//   o_busy            : not idle
//   o_tick            : one pulse per consumed terminal count
//   o_done            : one pulse at one-shot completion
//   o_tick_cnt        : saturating ticks since last accepted command
module ttl269_sequencer
  import ttl269_sequencer_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int CNT_W      = 16
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  ttl269_sequencer_if.slave     i_cmd,
  input  logic                  i_pause,
  input  logic                  i_abort,
  output logic                  o_ctr_pe_n,
  output logic                  o_ctr_u_d,
  output logic                  o_ctr_cep_n,
  output logic                  o_ctr_cet_n,
  output logic [DATA_WIDTH-1:0] o_ctr_p,
  input  logic                  i_ctr_tc,
  output logic                  o_busy,
  output logic                  o_tick,
  output logic                  o_done,
  output logic [CNT_W-1:0]      o_tick_cnt
);
  state_t                r_state, w_next;
  logic [DATA_WIDTH-1:0] r_p;
  logic                  r_u_d;
  logic                  r_reload;

  logic w_accept, w_stop, w_term;
  logic w_pe_n, w_en_n, w_tick, w_done;

  assign w_accept = i_cmd.cmd_valid && (r_state == ST_IDLE) && !i_rst;
  // Reset acts like abort on the current cycle's decoded outputs.
  assign w_stop   = i_rst || i_abort;
  // TC is only meaningful while running; the counter itself is never reset.
  assign w_term   = (r_state == ST_RUN) && i_ctr_tc && !i_pause && !w_stop;

  always_comb begin
    w_next = r_state;
    w_pe_n = DEASSERT_N;
    w_en_n = DEASSERT_N;
    w_tick = 1'b0;
    w_done = 1'b0;
    case (r_state)
      ST_IDLE: if (w_accept) w_next = ST_LOAD;
      ST_LOAD: begin
        w_pe_n = ASSERT_N;
        w_next = ST_RUN;
      end
      ST_RUN: begin
        w_en_n = i_pause ? DEASSERT_N : ASSERT_N;
        if (w_term) begin
          w_tick = 1'b1;
          if (r_reload) begin
            // Synchronous load overrides count in the part.
            w_pe_n = ASSERT_N;
          end else begin
            // Freeze on the terminal value.
            w_en_n = DEASSERT_N;
            w_next = ST_DONE;
          end
        end
      end
      ST_DONE: begin
        w_done = 1'b1;
        w_next = ST_IDLE;
      end
      default: w_next = ST_IDLE;
    endcase
    if (w_stop && (r_state != ST_IDLE)) begin
      w_next = ST_IDLE;
      w_pe_n = DEASSERT_N;
      w_en_n = DEASSERT_N;
      w_tick = 1'b0;
      w_done = 1'b0;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state  <= ST_IDLE;
      r_p      <= '0;
      r_u_d    <= 1'b1;
      r_reload <= 1'b0;
    end else begin
      r_state <= w_next;
      if (w_accept) begin
        r_p      <= i_cmd.cmd_value;
        r_u_d    <= i_cmd.cmd_up;
        r_reload <= i_cmd.cmd_reload;
      end
    end
  end

  ttl269_sequencer_sat_counter #(.CNT_W(CNT_W)) u_tick_cnt (
    .i_clk (i_clk),
    .i_rst (i_rst),
    .i_clr (w_accept),
    .i_inc (w_tick),
    .o_cnt (o_tick_cnt)
  );

  assign i_cmd.cmd_ready = (r_state == ST_IDLE) && !i_rst;
  assign o_ctr_pe_n      = w_pe_n;
  assign o_ctr_cep_n     = w_en_n;
  assign o_ctr_cet_n     = w_en_n;
  assign o_ctr_p         = r_p;
  assign o_ctr_u_d       = r_u_d;
  assign o_busy          = (r_state != ST_IDLE);
  assign o_tick          = w_tick;
  assign o_done          = w_done;
endmodule

// File: tb/tb_ttl269_sequencer.sv
// tb_ttl269_sequencer
//   Sequencer driving a behavioural MC74F269 model; every cycle's outputs
//   are compared with a distance-to-terminal reference model.
module tb_ttl269_sequencer;
  localparam int DW = 8;
  localparam int CW = 4;

  logic clk = 1'b0;
  logic rst, pause, abort;
  logic pe_n, u_d, cep_n, cet_n, tc, busy, tick, done;
  logic [DW-1:0] p;
  logic [CW-1:0] tick_cnt;

  always #5 clk = ~clk;

  ttl269_sequencer_if #(.DATA_WIDTH(DW)) cmd_if ();

  ttl269_sequencer #(.DATA_WIDTH(DW), .CNT_W(CW)) dut (
    .i_clk(clk), .i_rst(rst), .i_cmd(cmd_if.slave),
    .i_pause(pause), .i_abort(abort),
    .o_ctr_pe_n(pe_n), .o_ctr_u_d(u_d), .o_ctr_cep_n(cep_n), .o_ctr_cet_n(cet_n),
    .o_ctr_p(p), .i_ctr_tc(tc),
    .o_busy(busy), .o_tick(tick), .o_done(done), .o_tick_cnt(tick_cnt)
  );

  // Behavioural 74F269: no reset, sync load beats count, comb TC.
  logic [DW-1:0] q;
  initial q = DW'($urandom);
  always @(posedge clk) begin
    if (!pe_n)               q <= p;
    else if (!cep_n && !cet_n) q <= u_d ? q + 1'b1 : q - 1'b1;
  end
  assign tc = u_d ? (q == 8'hFF) : (q == 8'h00);

  int n_chk = 0, n_fail = 0;
  int cyc = 0, acc_cyc = -1, done_cyc = -1;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s @cyc %0d: got %0h expected %0h", tag, cyc, act, exp);
    end
  endtask

  // Reference model: distance (in steps) from the current count to terminal.
  bit       m_active = 0, m_loading = 0, m_fin = 0, m_rl = 0;
  int       m_dist = 0, m_init = 0, m_tcnt = 0;
  bit [7:0] m_p = 0;
  bit       m_u = 1;

  task automatic step(input logic v, input logic [7:0] val, input logic up, input logic rl,
                      input logic pz, input logic ab, input logic rs);
    logic term, e_tick, e_done, e_pe, e_en, e_ready;
    @(negedge clk);
    cmd_if.cmd_valid = v; cmd_if.cmd_value = val; cmd_if.cmd_up = up; cmd_if.cmd_reload = rl;
    pause = pz; abort = ab; rst = rs;
    #1;
    cyc++;
    e_tick = 0; e_done = 0; e_pe = 1; e_en = 1; term = 0;
    e_ready = !m_active && !rs;
    if (m_active && !rs && !ab) begin
      if (m_loading) e_pe = 0;
      else if (m_fin) e_done = 1;
      else begin
        term   = (m_dist == 0) && !pz;
        e_tick = term;
        e_en   = pz;
        if (term) begin
          if (m_rl) e_pe = 0;
          else      e_en = 1;
        end
      end
    end
    chk("cmd_ready", cmd_if.cmd_ready, e_ready);
    chk("tick", tick, e_tick);
    chk("done", done, e_done);
    chk("pe_n", pe_n, e_pe);
    chk("cep_n", cep_n, e_en);
    chk("cet_n", cet_n, e_en);
    chk("tick_cnt", tick_cnt, m_tcnt);
    chk("ctr_p", p, m_p);
    chk("ctr_u_d", u_d, m_u);
    if (!rs) chk("busy", busy, m_active);
    if (m_active && !m_loading && !m_fin)
      chk("q", q, m_u ? 255 - m_dist : m_dist);
    if (done) done_cyc = cyc;
    // advance model to the next cycle
    if (rs) begin
      m_active = 0; m_tcnt = 0; m_p = 0; m_u = 1;
    end else if (!m_active) begin
      if (v) begin
        m_active = 1; m_loading = 1; m_fin = 0;
        m_p = val; m_u = up; m_rl = rl;
        m_init = up ? 255 - val : val;
        m_dist = m_init; m_tcnt = 0; acc_cyc = cyc;
      end
    end else if (ab || m_fin) begin
      m_active = 0;
    end else if (m_loading) begin
      m_loading = 0;
    end else if (term) begin
      if (m_tcnt < 15) m_tcnt++;
      if (m_rl) m_dist = m_init;
      else      m_fin = 1;
    end else if (!pz) begin
      m_dist--;
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(0, 8'h00, 0, 0, 0, 0, 0);
  endtask

  initial begin
    cmd_if.cmd_valid = 0; cmd_if.cmd_value = 0; cmd_if.cmd_up = 0; cmd_if.cmd_reload = 0;
    pause = 0; abort = 0; rst = 1;
    repeat (2) @(posedge clk);
    step(0, 8'h00, 0, 0, 0, 0, 1);
    step(0, 8'h00, 0, 0, 0, 0, 1);

    // up one-shot from FC: done 6 cycles after accept
    step(1, 8'hFC, 1, 0, 0, 0, 0);
    idle(8);
    chk("done_latency", done_cyc - acc_cyc, 6);

    // down auto-reload from 03: period 4
    step(1, 8'h03, 0, 1, 0, 0, 0);
    idle(22);
    chk("reload_tick_cnt", tick_cnt, 5);
    step(0, 8'h00, 0, 0, 0, 1, 0);
    idle(2);

    // pause across the terminal cycle
    step(1, 8'hFE, 1, 0, 0, 0, 0);
    step(0, 8'h00, 0, 0, 1, 0, 0);   // LOAD ignores pause
    step(0, 8'h00, 0, 0, 0, 0, 0);   // Q=FE
    for (int i = 0; i < 3; i++) step(0, 8'h00, 0, 0, 1, 0, 0);
    idle(5);

    // abort, then reset, two cycles into RUN
    step(1, 8'h10, 1, 1, 0, 0, 0);
    idle(3);
    step(0, 8'h00, 0, 0, 0, 1, 0);
    idle(2);
    step(1, 8'hFF, 1, 1, 0, 0, 0);
    idle(3);
    step(0, 8'h00, 0, 0, 0, 0, 1);
    idle(2);

    // immediate terminal with saturation
    step(1, 8'hFF, 1, 1, 0, 0, 0);
    idle(20);
    chk("sat_tick_cnt", tick_cnt, 4'hF);
    step(0, 8'h00, 0, 0, 0, 1, 0);

    // valid held while busy; new value taken once idle
    step(1, 8'h02, 0, 0, 0, 0, 0);
    for (int i = 0; i < 8; i++) step(1, 8'h55 + 8'(i), 1, 0, 0, 0, 0);
    idle(10);

    // randomized traffic
    for (int i = 0; i < 2500; i++) begin
      logic v, up, rl, pz, ab, rs;
      logic [7:0] val;
      v  = ($urandom_range(0, 2) == 0);
      up = 1'($urandom);
      rl = 1'($urandom);
      if ($urandom_range(0, 1) == 1) val = up ? 8'(255 - $urandom_range(0, 5)) : 8'($urandom_range(0, 5));
      else                           val = 8'($urandom);
      pz = ($urandom_range(0, 4) == 0);
      ab = ($urandom_range(0, 60) == 0);
      rs = ($urandom_range(0, 150) == 0);
      step(v, val, up, rl, pz, ab, rs);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
